// File: rtl/pipe_pkg.sv
// Shared encodings and control-field grouping for the decode/execute boundary
// of the RV32I pipeline.
package pipe_pkg;

   localparam logic [1:0] RES_ALU  = 2'b00;
   localparam logic [1:0] RES_LOAD = 2'b01;
   localparam logic [1:0] RES_PC4  = 2'b10;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_TGT = 2'b01;
   localparam logic [1:0] PC_ALU = 2'b10;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
      logic [1:0] jump;
      logic       branch;
      logic [2:0] alu_control;
      logic       alu_src;
   } de_ctrl_t;

   // All-zero control: no write-back, no store, no redirect in execute.
   localparam de_ctrl_t DE_CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_reg_de_hazard_detect.sv
// Load-use and redirect detection for the decode/execute boundary; purely
// combinational, fed by execute's redirect request and the registered E slot.
module hazard_detect
   import pipe_pkg::*;
(
   input  logic       rst,
   input  logic [1:0] pcsrc_e,
   input  logic [4:0] rs1_d,
   input  logic [4:0] rs2_d,
   input  logic       valid_d,
   input  logic       valid_e,
   input  logic       reg_write_e,
   input  logic [1:0] result_src_e,
   input  logic [4:0] rd_e,
   output logic       redirect,
   output logic       lduse,
   output logic       stall_f,
   output logic       stall_d,
   output logic       flush_d
);

   always_comb begin
      redirect = (pcsrc_e != PC_SEQ);
      // Rs fields are compared regardless of use; occasional false stalls are accepted.
      lduse    = valid_e & reg_write_e & (result_src_e == RES_LOAD) & (rd_e != 5'd0) &
                 ((rd_e == rs1_d) | (rd_e == rs2_d)) & valid_d;

      stall_f = 1'b0;
      stall_d = 1'b0;
      flush_d = 1'b0;
      if (!rst) begin
         // Decode holds a wrong-path instruction on redirect, so flushing beats stalling.
         if (redirect) begin
            flush_d = 1'b1;
         end else if (lduse) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pipe_reg_de.sv
// Decode-to-execute pipeline register with bubble insertion on load-use and
// redirect, plus saturating stall/flush event counters.
module pipe_reg_de
   import pipe_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             RegWriteD_i,
   input  logic [1:0]       ResultSrcD_i,
   input  logic             MemWriteD_i,
   input  logic [1:0]       JumpD_i,
   input  logic             BranchD_i,
   input  logic [2:0]       ALUControlD_i,
   input  logic             ALUSrcD_i,
   input  logic [XLEN-1:0]  RD1D_i,
   input  logic [XLEN-1:0]  RD2D_i,
   input  logic [XLEN-1:0]  PCD_i,
   input  logic [XLEN-1:0]  PCPlus4D_i,
   input  logic [XLEN-1:0]  ImmExtD_i,
   input  logic [4:0]       Rs1D_i,
   input  logic [4:0]       Rs2D_i,
   input  logic [4:0]       RdD_i,
   input  logic             ValidD_i,
   input  logic [1:0]       PCSrcE_i,
   output logic             RegWriteE_o,
   output logic [1:0]       ResultSrcE_o,
   output logic             MemWriteE_o,
   output logic [1:0]       JumpE_o,
   output logic             BranchE_o,
   output logic [2:0]       ALUControlE_o,
   output logic             ALUSrcE_o,
   output logic [XLEN-1:0]  RD1E_o,
   output logic [XLEN-1:0]  RD2E_o,
   output logic [XLEN-1:0]  PCE_o,
   output logic [XLEN-1:0]  PCPlus4E_o,
   output logic [XLEN-1:0]  ImmExtE_o,
   output logic [4:0]       Rs1E_o,
   output logic [4:0]       Rs2E_o,
   output logic [4:0]       RdE_o,
   output logic             ValidE_o,
   output logic             StallF_o,
   output logic             StallD_o,
   output logic             FlushD_o,
   output logic [CNT_W-1:0] StallCnt_o,
   output logic [CNT_W-1:0] FlushCnt_o
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      if (c == {CNT_W{1'b1}}) return c;
      return c + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   de_ctrl_t        ctrl_d;
   de_ctrl_t        ctrl_p1;
   logic [XLEN-1:0] rd1_p1, rd2_p1, pc_p1, pc4_p1, imm_p1;
   logic [4:0]      rs1_p1, rs2_p1, rd_p1;
   logic            vld_p1;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic            redirect, lduse, bubble;

   assign ctrl_d = '{reg_write:   RegWriteD_i,
                     result_src:  ResultSrcD_i,
                     mem_write:   MemWriteD_i,
                     jump:        JumpD_i,
                     branch:      BranchD_i,
                     alu_control: ALUControlD_i,
                     alu_src:     ALUSrcD_i};

   hazard_detect u_hazard (
      .rst          (rst),
      .pcsrc_e      (PCSrcE_i),
      .rs1_d        (Rs1D_i),
      .rs2_d        (Rs2D_i),
      .valid_d      (ValidD_i),
      .valid_e      (vld_p1),
      .reg_write_e  (ctrl_p1.reg_write),
      .result_src_e (ctrl_p1.result_src),
      .rd_e         (rd_p1),
      .redirect     (redirect),
      .lduse        (lduse),
      .stall_f      (StallF_o),
      .stall_d      (StallD_o),
      .flush_d      (FlushD_o)
   );

   assign bubble = redirect | lduse;

   // Decode -> execute stage boundary
   always_ff @(posedge clk) begin
      if (rst || bubble) begin
         ctrl_p1 <= DE_CTRL_BUBBLE;
         vld_p1  <= 1'b0;
         rd1_p1  <= '0;
         rd2_p1  <= '0;
         pc_p1   <= '0;
         pc4_p1  <= '0;
         imm_p1  <= '0;
         rs1_p1  <= '0;
         rs2_p1  <= '0;
         rd_p1   <= '0;
      end else begin
         ctrl_p1 <= ctrl_d;
         vld_p1  <= ValidD_i;
         rd1_p1  <= RD1D_i;
         rd2_p1  <= RD2D_i;
         pc_p1   <= PCD_i;
         pc4_p1  <= PCPlus4D_i;
         imm_p1  <= ImmExtD_i;
         rs1_p1  <= Rs1D_i;
         rs2_p1  <= Rs2D_i;
         rd_p1   <= RdD_i;
      end
   end

   // A stall cycle that coincides with a redirect counts only as a flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (redirect) flush_cnt <= sat_inc(flush_cnt);
         if (lduse && !redirect) stall_cnt <= sat_inc(stall_cnt);
      end
   end

   assign RegWriteE_o   = ctrl_p1.reg_write;
   assign ResultSrcE_o  = ctrl_p1.result_src;
   assign MemWriteE_o   = ctrl_p1.mem_write;
   assign JumpE_o       = ctrl_p1.jump;
   assign BranchE_o     = ctrl_p1.branch;
   assign ALUControlE_o = ctrl_p1.alu_control;
   assign ALUSrcE_o     = ctrl_p1.alu_src;
   assign RD1E_o        = rd1_p1;
   assign RD2E_o        = rd2_p1;
   assign PCE_o         = pc_p1;
   assign PCPlus4E_o    = pc4_p1;
   assign ImmExtE_o     = imm_p1;
   assign Rs1E_o        = rs1_p1;
   assign Rs2E_o        = rs2_p1;
   assign RdE_o         = rd_p1;
   assign ValidE_o      = vld_p1;
   assign StallCnt_o    = stall_cnt;
   assign FlushCnt_o    = flush_cnt;

endmodule

// File: tb/tb_pipe_reg_de.sv
// Self-checking bench for pipe_reg_de: directed scenarios plus randomized
// traffic against a slot-level reference model.
module tb_pipe_reg_de;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;
   localparam int MAXC  = (1 << CNT_W) - 1;

   typedef struct packed {
      logic        rw;
      logic [1:0]  rs;
      logic        mw;
      logic [1:0]  j;
      logic        b;
      logic [2:0]  alu;
      logic        as;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        v;
   } slot_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   slot_t      d = '0;
   logic [1:0] pcsrc = 2'b00;

   logic             RegWriteE_o, MemWriteE_o, BranchE_o, ALUSrcE_o, ValidE_o;
   logic [1:0]       ResultSrcE_o, JumpE_o;
   logic [2:0]       ALUControlE_o;
   logic [XLEN-1:0]  RD1E_o, RD2E_o, PCE_o, PCPlus4E_o, ImmExtE_o;
   logic [4:0]       Rs1E_o, Rs2E_o, RdE_o;
   logic             StallF_o, StallD_o, FlushD_o;
   logic [CNT_W-1:0] StallCnt_o, FlushCnt_o;

   slot_t      e_act;
   logic [2:0] fl;
   assign e_act = {RegWriteE_o, ResultSrcE_o, MemWriteE_o, JumpE_o, BranchE_o, ALUControlE_o,
                   ALUSrcE_o, RD1E_o, RD2E_o, PCE_o, PCPlus4E_o, ImmExtE_o, Rs1E_o, Rs2E_o,
                   RdE_o, ValidE_o};
   assign fl = {StallF_o, StallD_o, FlushD_o};

   // Reference state: the instruction occupying execute and the event totals.
   slot_t m_e = '0;
   int    m_sc = 0;
   int    m_fc = 0;
   int    n_tests = 0;
   int    n_fail = 0;

   pipe_reg_de #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .RegWriteD_i(d.rw), .ResultSrcD_i(d.rs), .MemWriteD_i(d.mw), .JumpD_i(d.j),
      .BranchD_i(d.b), .ALUControlD_i(d.alu), .ALUSrcD_i(d.as),
      .RD1D_i(d.rd1), .RD2D_i(d.rd2), .PCD_i(d.pc), .PCPlus4D_i(d.pc4), .ImmExtD_i(d.imm),
      .Rs1D_i(d.rs1), .Rs2D_i(d.rs2), .RdD_i(d.rd), .ValidD_i(d.v), .PCSrcE_i(pcsrc),
      .RegWriteE_o(RegWriteE_o), .ResultSrcE_o(ResultSrcE_o), .MemWriteE_o(MemWriteE_o),
      .JumpE_o(JumpE_o), .BranchE_o(BranchE_o), .ALUControlE_o(ALUControlE_o),
      .ALUSrcE_o(ALUSrcE_o), .RD1E_o(RD1E_o), .RD2E_o(RD2E_o), .PCE_o(PCE_o),
      .PCPlus4E_o(PCPlus4E_o), .ImmExtE_o(ImmExtE_o), .Rs1E_o(Rs1E_o), .Rs2E_o(Rs2E_o),
      .RdE_o(RdE_o), .ValidE_o(ValidE_o), .StallF_o(StallF_o), .StallD_o(StallD_o),
      .FlushD_o(FlushD_o), .StallCnt_o(StallCnt_o), .FlushCnt_o(FlushCnt_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Execute holds a load whose destination decode reads.
   function automatic logic m_lduse();
      return m_e.v && m_e.rw && (m_e.rs == 2'b01) && (m_e.rd != 5'd0) &&
             ((m_e.rd == d.rs1) || (m_e.rd == d.rs2)) && d.v;
   endfunction

   // Expected {StallF, StallD, FlushD}.
   function automatic logic [2:0] m_flags();
      if (rst) return 3'b000;
      if (pcsrc != 2'b00) return 3'b001;
      if (m_lduse()) return 3'b110;
      return 3'b000;
   endfunction

   task automatic tick();
      logic redir, ld;
      redir = (pcsrc != 2'b00);
      ld    = m_lduse();
      @(posedge clk);
      #1;
      if (rst) begin
         m_e  = '0;
         m_sc = 0;
         m_fc = 0;
      end else begin
         m_e = (redir || ld) ? slot_t'('0) : d;
         if (redir) m_fc = (m_fc < MAXC) ? m_fc + 1 : m_fc;
         else if (ld) m_sc = (m_sc < MAXC) ? m_sc + 1 : m_sc;
      end
   endtask

   task automatic rand_d();
      logic [191:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      d = slot_t'(r[186:0]);
      if ($urandom_range(0, 2) == 0) d.rs = 2'b01;
      if ($urandom_range(0, 1) == 0) d.rs1 = m_e.rd;
      if ($urandom_range(0, 3) == 0) d.rs2 = m_e.rd;
      d.v = ($urandom_range(0, 9) != 0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rand_d();
      pcsrc = 2'($urandom_range(0, 3));
      #1;
      n_tests++;
      if (fl !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 000", fl);
      end
      tick();
      rand_d();
      pcsrc = 2'b01;
      #1;
      n_tests++;
      if (fl !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags_redirect: got %b expected 000", fl);
      end
      tick();
      n_tests++;
      if (e_act !== slot_t'('0)) begin
         n_fail++; $display("FAIL reset_e_slot: got %h expected 0", e_act);
      end
      n_tests++;
      if (StallCnt_o !== '0 || FlushCnt_o !== '0) begin
         n_fail++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", StallCnt_o, FlushCnt_o);
      end
      rst = 1'b0;
      pcsrc = 2'b00;
   endtask

   task automatic test_pass_through();
      d = '0;
      d.rw = 1'b1; d.as = 1'b1; d.rd = 5'd5; d.rs1 = 5'd1;
      d.imm = 32'h0000_0010; d.pc = 32'h100; d.pc4 = 32'h104; d.v = 1'b1;
      pcsrc = 2'b00;
      #1;
      n_tests++;
      if (fl !== 3'b000) begin
         n_fail++; $display("FAIL pass_flags: got %b expected 000", fl);
      end
      tick();
      n_tests++;
      if (RdE_o !== 5'd5 || ImmExtE_o !== 32'h10 || PCE_o !== 32'h100 || ValidE_o !== 1'b1) begin
         n_fail++;
         $display("FAIL pass_fields: got rd=%0d imm=%h pc=%h v=%b expected 5 10 100 1",
                  RdE_o, ImmExtE_o, PCE_o, ValidE_o);
      end
      n_tests++;
      if (e_act !== d) begin
         n_fail++; $display("FAIL pass_slot: got %h expected %h", e_act, d);
      end
   endtask

   task automatic test_load_use();
      int sc0;
      sc0 = m_sc;
      d = '0;
      d.rw = 1'b1; d.rs = 2'b01; d.rd = 5'd6; d.rs1 = 5'd2; d.imm = 32'd4; d.v = 1'b1;
      #1;
      tick();
      d = '0;
      d.rw = 1'b1; d.rs1 = 5'd6; d.rs2 = 5'd7; d.rd = 5'd8; d.v = 1'b1;
      #1;
      n_tests++;
      if (fl !== 3'b110) begin
         n_fail++; $display("FAIL lduse_flags: got %b expected 110", fl);
      end
      tick();
      n_tests++;
      if (e_act !== slot_t'('0)) begin
         n_fail++; $display("FAIL lduse_bubble: got %h expected 0", e_act);
      end
      n_tests++;
      if (StallCnt_o !== CNT_W'(sc0 + 1)) begin
         n_fail++; $display("FAIL lduse_stallcnt: got %0d expected %0d", StallCnt_o, sc0 + 1);
      end
      #1;
      n_tests++;
      if (fl !== 3'b000) begin
         n_fail++; $display("FAIL lduse_one_cycle: got %b expected 000", fl);
      end
      tick();
      n_tests++;
      if (e_act !== d) begin
         n_fail++; $display("FAIL lduse_release: got %h expected %h", e_act, d);
      end
      d = '0;
      d.rw = 1'b1; d.rs = 2'b01; d.rd = 5'd0; d.v = 1'b1;
      #1;
      tick();
      d = '0;
      d.rw = 1'b1; d.rs1 = 5'd0; d.rd = 5'd3; d.v = 1'b1;
      #1;
      n_tests++;
      if (fl !== 3'b000) begin
         n_fail++; $display("FAIL lduse_x0: got %b expected 000", fl);
      end
      tick();
      n_tests++;
      if (StallCnt_o !== CNT_W'(sc0 + 1)) begin
         n_fail++; $display("FAIL lduse_x0_cnt: got %0d expected %0d", StallCnt_o, sc0 + 1);
      end
   endtask

   task automatic test_redirect();
      logic [1:0] kinds [2];
      int         fc0;
      kinds[0] = 2'b01;
      kinds[1] = 2'b10;
      for (int k = 0; k < 2; k++) begin
         fc0 = m_fc;
         rand_d();
         d.v = 1'b1;
         pcsrc = kinds[k];
         #1;
         n_tests++;
         if (fl !== 3'b001) begin
            n_fail++; $display("FAIL redirect_flags_%b: got %b expected 001", kinds[k], fl);
         end
         tick();
         n_tests++;
         if (e_act !== slot_t'('0)) begin
            n_fail++; $display("FAIL redirect_bubble_%b: got %h expected 0", kinds[k], e_act);
         end
         n_tests++;
         if (FlushCnt_o !== CNT_W'(fc0 + 1)) begin
            n_fail++;
            $display("FAIL redirect_cnt_%b: got %0d expected %0d", kinds[k], FlushCnt_o, fc0 + 1);
         end
      end
      pcsrc = 2'b00;
   endtask

   task automatic test_simultaneous();
      int sc0, fc0;
      d = '0;
      d.rw = 1'b1; d.rs = 2'b01; d.rd = 5'd9; d.v = 1'b1;
      pcsrc = 2'b00;
      #1;
      tick();
      sc0 = m_sc;
      fc0 = m_fc;
      d = '0;
      d.rs2 = 5'd9; d.rd = 5'd10; d.rw = 1'b1; d.v = 1'b1;
      pcsrc = 2'b01;
      #1;
      n_tests++;
      if (fl !== 3'b001) begin
         n_fail++; $display("FAIL simul_flags: got %b expected 001", fl);
      end
      tick();
      n_tests++;
      if (FlushCnt_o !== CNT_W'(fc0 + 1) || StallCnt_o !== CNT_W'(sc0)) begin
         n_fail++;
         $display("FAIL simul_counts: got flush=%0d stall=%0d expected %0d %0d",
                  FlushCnt_o, StallCnt_o, fc0 + 1, sc0);
      end
      pcsrc = 2'b00;
   endtask

   task automatic test_reset_mid_stall();
      d = '0;
      d.rw = 1'b1; d.rs = 2'b01; d.rd = 5'd3; d.v = 1'b1;
      #1;
      tick();
      d = '0;
      d.rs1 = 5'd3; d.v = 1'b1; d.rw = 1'b1; d.rd = 5'd4;
      rst = 1'b1;
      #1;
      n_tests++;
      if (fl !== 3'b000) begin
         n_fail++; $display("FAIL rst_mid_flags: got %b expected 000", fl);
      end
      tick();
      n_tests++;
      if (e_act !== slot_t'('0) || StallCnt_o !== '0 || FlushCnt_o !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_state: got %h %0d %0d expected 0 0 0", e_act, StallCnt_o, FlushCnt_o);
      end
      rst = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rand_d();
         pcsrc = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         #1;
         n_tests++;
         if (fl !== m_flags()) begin
            n_fail++; $display("FAIL rand_flags[%0d]: got %b expected %b", i, fl, m_flags());
         end
         tick();
         n_tests++;
         if (e_act !== m_e) begin
            n_fail++; $display("FAIL rand_slot[%0d]: got %h expected %h", i, e_act, m_e);
         end
         n_tests++;
         if (StallCnt_o !== CNT_W'(m_sc) || FlushCnt_o !== CNT_W'(m_fc)) begin
            n_fail++;
            $display("FAIL rand_cnt[%0d]: got %0d/%0d expected %0d/%0d",
                     i, StallCnt_o, FlushCnt_o, m_sc, m_fc);
         end
      end
      pcsrc = 2'b00;
   endtask

   task automatic test_saturation();
      int exp_c;
      rst = 1'b1;
      #1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         rand_d();
         pcsrc = 2'b01;
         #1;
         tick();
         exp_c = (i + 1 > MAXC) ? MAXC : i + 1;
         n_tests++;
         if (FlushCnt_o !== CNT_W'(exp_c)) begin
            n_fail++; $display("FAIL sat_step[%0d]: got %0d expected %0d", i, FlushCnt_o, exp_c);
         end
      end
      n_tests++;
      if (FlushCnt_o !== 4'd15) begin
         n_fail++; $display("FAIL sat_hold: got %0d expected 15", FlushCnt_o);
      end
      rst = 1'b1;
      #1;
      tick();
      n_tests++;
      if (FlushCnt_o !== '0) begin
         n_fail++; $display("FAIL sat_reset: got %0d expected 0", FlushCnt_o);
      end
      rst = 1'b0;
      #1;
      tick();
      n_tests++;
      if (FlushCnt_o !== 4'd1) begin
         n_fail++; $display("FAIL sat_restart: got %0d expected 1", FlushCnt_o);
      end
      pcsrc = 2'b00;
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_load_use();
      test_redirect();
      test_simultaneous();
      test_reset_mid_stall();
      test_random();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_reg_de.md
Name: pipe_reg_de

Overview:
- Decode-to-execute pipeline register for the 5-stage RV32I core.
- Captures all decode control and data fields each cycle and presents them to the execute stage.
- Contains the load-use hazard detector, and inserts bubbles on load-use stalls and on taken branches/jumps reported back by execute.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
XLEN, 32, datapath width
CNT_W, 16, width of each saturating event counter

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
RegWriteD_i  input  1  decode register-write enable
ResultSrcD_i  input  2  decode result select (01 = load)
MemWriteD_i  input  1  decode store enable
JumpD_i  input  2  decode jump/branch class
BranchD_i  input  1  decode branch flag
ALUControlD_i  input  3  decode ALU op
ALUSrcD_i  input  1  decode ALU B-source select
RD1D_i, RD2D_i  input  XLEN  register file read data
PCD_i, PCPlus4D_i, ImmExtD_i  input  XLEN  decode PC, PC+4, extended immediate
Rs1D_i, Rs2D_i, RdD_i  input  5  decode register indices
ValidD_i  input  1  decode slot holds a real instruction
PCSrcE_i  input  2  execute redirect (00 = none)
(all D fields above have E-named registered outputs of equal width) RegWriteE_o, ResultSrcE_o, MemWriteE_o, JumpE_o, BranchE_o, ALUControlE_o, ALUSrcE_o, RD1E_o, RD2E_o, PCE_o, PCPlus4E_o, ImmExtE_o, Rs1E_o, Rs2E_o, RdE_o, ValidE_o  output
StallF_o  output  1  hold PC register
StallD_o  output  1  hold fetch/decode register
FlushD_o  output  1  clear fetch/decode register
StallCnt_o  output  CNT_W  load-use stall events
FlushCnt_o  output  CNT_W  redirect flush events

Behaviour:
- Bubble is defined as: all control fields 0 (RegWrite=0, ResultSrc=00, MemWrite=0, Jump=00, Branch=0, ALUControl=000, ALUSrc=0), ValidE=0, data and index fields 0.
  - Jump=00 with Branch=0 yields no redirect in execute.
- Reset (rst=1 at the clock edge): all E outputs take the bubble value and both counters go to 0.
  - Applies mid-stall or mid-flush: the next cycle after reset is a clean bubble.
- Redirect condition: redirect = (PCSrcE_i != 00).
- Load-use condition: lduse = ValidE_o & RegWriteE_o & (ResultSrcE_o==01) & (RdE_o!=0) & ((RdE_o==Rs1D_i) | (RdE_o==Rs2D_i)) & ValidD_i.
  - Rs fields are compared even for instructions that do not use them. The resulting false stalls are accepted.
- Combinational outputs, evaluated in priority order:
  - redirect=1: FlushD_o=1, StallF_o=0, StallD_o=0. Redirect takes priority over lduse, because the decode instruction is wrong-path.
  - else lduse=1: StallF_o=1, StallD_o=1, FlushD_o=0.
  - else: all three are 0.
  - All three are 0 while rst=1.
- Next-state of the E registers:
  - redirect or lduse: load the bubble.
  - otherwise: load all D inputs unchanged. Latency is 1 cycle.
- A stalled load-use lasts exactly 1 cycle, since the bubble clears the condition on the next cycle.
  - Back-to-back loads each stall independently.
- Counters:
  - FlushCnt increments on each cycle with redirect=1.
  - StallCnt increments on each cycle with lduse=1 and redirect=0.
  - Both saturate at 2^CNT_W-1 and never wrap.
- There is no combinational path from D inputs to E outputs.
  - The only combinational paths to StallF_o, StallD_o and FlushD_o come from PCSrcE_i, from Rs1D_i, Rs2D_i and ValidD_i, and from the registered E state.

Decomposition:
- Shared package pipe_pkg contains:
  - ResultSrc encodings (RES_ALU=00, RES_LOAD=01, RES_PC4=10).
  - PCSrc encodings (PC_SEQ=00, PC_TGT=01, PC_ALU=10).
  - A packed struct de_ctrl_t grouping the control fields.
  - A constant DE_CTRL_BUBBLE.
- One combinational sub-module, hazard_detect, computes lduse, redirect, StallF/StallD/FlushD.
- Registers and counters stay in pipe_reg_de.

Test Plan:
- Reset: drive random D inputs with rst=1 for 2 cycles -> all E outputs 0, ValidE_o=0, counters 0, Stall/Flush outputs 0.
- Pass-through: ADDI with RdD=5, ImmExtD=0x0000_0010, PCD=0x100 -> next cycle RdE_o=5, ImmExtE_o=0x10, PCE_o=0x100, ValidE_o=1, no stall.
- Load-use: LW x6 in E (ResultSrcE=01, RdE=6), decode Rs1D=6 -> StallF_o=StallD_o=1 for exactly 1 cycle, E bubble next cycle, StallCnt=1. Repeat with RdE=0 -> no stall.
- Redirect: PCSrcE_i=01 while decode holds a valid instruction -> FlushD_o=1, next E is bubble, FlushCnt=1. Same with PCSrcE_i=10 -> same response.
- Simultaneous: lduse true and PCSrcE_i=01 in the same cycle -> FlushD_o=1, StallF_o=StallD_o=0, FlushCnt+1, StallCnt unchanged.
- Saturation, with CNT_W=4: 20 consecutive redirects -> FlushCnt_o holds 15. Asserting rst mid-sequence -> counter 0 next cycle.
